uart_tx_stream_arbiter: RTL
===========================

Name: uart_tx_stream_arbiter

Overview:
Shares the single UART transmitter's AXI-Stream byte input among NUM_SRC byte-stream producers, such as the Wishbone bridge response path and a debug/status streamer. Arbitration is round-robin at packet granularity: a granted source keeps the transmitter until its tlast beat is accepted, or until a stall watchdog revokes the grant. The block sits between the producers and the uart s_axis port, in the i_clk (120 MHz PLL) domain.

Parameters:
NUM_SRC, 2, number of requesting stream sources (1..8)
DATA_WIDTH, 8, byte-stream data width
TIMEOUT_CYCLES, 4096, cycles of granted-source tvalid low (mid-packet) before the grant is revoked; 0 disables the watchdog

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
s_axis_tdata  input  NUM_SRC*DATA_WIDTH  per-source data, source k at bits [k*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  input  NUM_SRC  per-source valid
s_axis_tlast  input  NUM_SRC  per-source end-of-packet
s_axis_tready  output  NUM_SRC  per-source ready
m_axis_tdata  output  DATA_WIDTH  to uart s_axis_tdata
m_axis_tvalid  output  1  to uart s_axis_tvalid
m_axis_tlast  output  1  end-of-packet marker for downstream (unused by uart)
m_axis_tready  input  1  from uart s_axis_tready
o_grant  output  NUM_SRC  one-hot current grant; all-zero when idle
o_busy  output  1  high while in GRANT state
o_timeout  output  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid/tdata/tlast=0, s_axis_tready=0, o_grant=0, o_busy=0, o_timeout=0, state=IDLE, last_grant=NUM_SRC-1 (source 0 wins first), watchdog=0.
- Reset asserted mid-packet: all state is cleared immediately; any beat held in the output register is discarded. No recovery of partial packets.
- Output register: single-entry. Register loads when (!m_axis_tvalid || m_axis_tready). s_axis_tready[g] = grant[g] && state==GRANT && (!m_axis_tvalid || m_axis_tready); every other ready is 0. Source-to-m_axis latency is 1 cycle. Full throughput of 1 beat/cycle while granted.
- FSM IDLE: if any s_axis_tvalid is high, pick the first requester in rotating order last_grant+1, last_grant+2, … (mod NUM_SRC). Register the grant and go to GRANT. This is a 1-cycle arbitration bubble; no ready is asserted in IDLE.
- FSM GRANT: pass beats from the granted source. On an accepted beat with tlast=1, set last_grant=g, clear the grant, and go to IDLE in the next cycle.
  - Granted source dropping tvalid mid-packet keeps the grant.
  - Other sources' valid is ignored while in GRANT.
- Watchdog (TIMEOUT_CYCLES>0): in GRANT, increment every cycle the granted tvalid=0; clear on any accepted beat and on entry to GRANT. When it reaches TIMEOUT_CYCLES:
  - o_timeout pulses for 1 cycle.
  - The grant is cleared, last_grant=g, and the FSM goes to IDLE.
  - No tlast is synthesised.
  - A beat already in the output register still drains normally.
- Downstream backpressure (m_axis_tready=0) stalls the register; the watchdog does not count backpressure cycles.
- The tlast beat accepted in the same cycle other sources request: the next arbitration starts at g+1.
- A single continuously requesting source gets back-to-back packets, separated by the 1-cycle bubble.
- NUM_SRC=1 is legal: the grant is always source 0.

Decomposition:
- Shared package uart_arb_pkg: state enum {ARB_IDLE, ARB_GRANT}, default TIMEOUT_CYCLES, and the watchdog width function clog2(TIMEOUT_CYCLES+1).
- One sub-module, rr_pick: combinational rotate-priority selector. Inputs: req[NUM_SRC] and last_grant index. Outputs: one-hot grant and valid.
- FSM, output register, and watchdog live in the top module.

Test Plan:
- Src0 sends 3-byte packet 0x41,0x42,0x43(last) with m_tready=1 -> o_grant=01 one cycle after tvalid; m_axis shows the 3 bytes on 3 consecutive cycles, tlast on 0x43; IDLE follows.
- Src0 and src1 both valid from reset, each with 2-byte packets -> order is src0 packet, then src1, then src0 again. Packets never interleave, with a 1-cycle bubble between them.
- Src1 mid-packet holds tvalid=0 for 10 cycles while src0 requests -> grant stays 10, src0 tready=0, src1 packet then completes intact.
- TIMEOUT_CYCLES=16, src0 stalls after 1st byte -> o_timeout pulses at the 16th idle cycle, o_grant→00, and src1 is granted next.
- m_axis_tready=0 for 5 cycles mid-packet -> m_axis_tdata/tvalid held stable, s_axis_tready=0, no data loss, no timeout.
- i_rst_n pulsed low mid-packet -> all outputs 0 asynchronously; after release, src0 wins the first arbitration.

Source files
------------

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared types, defaults and width helpers for the UART
//                transmit stream arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Watchdog counter width; at least one bit so a disabled watchdog still
    // yields a legal vector width.
    function automatic int wd_width(input int timeout_cycles);
        if (timeout_cycles < 1) begin
            return 1;
        end
        return $clog2(timeout_cycles + 1);
    endfunction

    // Width of a source index; a single source still needs one bit.
    function automatic int idx_width(input int num_src);
        if (num_src < 2) begin
            return 1;
        end
        return $clog2(num_src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_stream_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating-priority selector. The search starts
//                at the source after i_last and wraps modulo NUM_SRC.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int NUM_SRC = 2,
    localparam int IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_SRC-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [2*NUM_SRC-1:0] w_req2;
    logic [IDX_W:0]       w_start;
    logic [NUM_SRC-1:0]   w_rot;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W+1:0]     w_sum;

    // Doubling the request vector lets a plain right shift act as a rotate.
    assign w_req2  = {i_req, i_req};
    assign w_start = {1'b0, i_last} + (IDX_W+1)'(1);
    assign w_rot   = NUM_SRC'(w_req2 >> w_start);
    assign o_valid = |i_req;

    // Lowest set bit of the rotated vector is the distance to the winner.
    always_comb begin
        w_off = '0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = IDX_W'(j);
            end
        end
    end

    // Undo the rotation: winner = (last + 1 + offset) mod NUM_SRC.
    always_comb begin
        w_sum = {1'b0, w_start} + {2'b00, w_off};
        if (w_sum >= (IDX_W+2)'(NUM_SRC)) begin
            w_sum = w_sum - (IDX_W+2)'(NUM_SRC);
        end
    end

    assign o_idx = IDX_W'(w_sum);

    // Expand the winning index to a one-hot grant.
    always_comb begin
        o_grant = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            o_grant[j] = o_valid && (o_idx == IDX_W'(j));
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_stream_arbiter
//  Description : Packet-granular round-robin arbiter sharing the UART
//                transmitter's byte stream among NUM_SRC producers, with a
//                single-entry output register and a mid-packet stall watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_stream_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [NUM_SRC-1:0]            o_grant,
    output logic                          o_busy,
    output logic                          o_timeout
);

    localparam int IDX_W = idx_width(NUM_SRC);
    localparam int WD_W  = wd_width(TIMEOUT_CYCLES);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [NUM_SRC-1:0]      r_grant;
    logic [IDX_W-1:0]        r_grant_idx;
    logic [IDX_W-1:0]        r_last_grant;
    logic [DATA_WIDTH-1:0]   r_m_tdata;
    logic                    r_m_tvalid;
    logic                    r_m_tlast;
    logic                    r_timeout;

    logic [NUM_SRC-1:0]      w_pick;
    logic [IDX_W-1:0]        w_pick_idx;
    logic                    w_pick_valid;
    logic                    w_load;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_accept;
    logic                    w_pkt_end;
    logic                    w_wd_expire;

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_pick (
        .i_req   (s_axis_tvalid),
        .i_last  (r_last_grant),
        .o_grant (w_pick),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // The output register can take a new beat when empty or draining.
    assign w_load      = !r_m_tvalid || m_axis_tready;
    assign w_sel_valid = |(s_axis_tvalid & r_grant);
    assign w_sel_last  = |(s_axis_tlast & r_grant);
    assign w_accept    = (r_state == ARB_GRANT) && w_load && w_sel_valid;
    assign w_pkt_end   = w_accept && w_sel_last;

    // One-hot AND-OR mux of the granted source's data.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (r_grant[k]) begin
                w_sel_data = w_sel_data | s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Stall watchdog: counts granted-source idle cycles, never backpressure.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            logic [WD_W-1:0] r_wd;

            // Counter clears outside GRANT, on accepted beats and on expiry.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_wd <= '0;
                end else if ((r_state != ARB_GRANT) || w_accept || w_wd_expire) begin
                    r_wd <= '0;
                end else if (!w_sel_valid) begin
                    r_wd <= r_wd + WD_W'(1);
                end
            end

            assign w_wd_expire = (r_state == ARB_GRANT) && !w_sel_valid &&
                                 (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_wd
            assign w_wd_expire = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE arbitrates for one cycle, GRANT holds until packet end
    // or watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (w_pkt_end || w_wd_expire) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Outputs decoded from the state: only the granted source sees ready.
    always_comb begin
        o_busy        = (r_state == ARB_GRANT);
        s_axis_tready = '0;
        if ((r_state == ARB_GRANT) && w_load) begin
            s_axis_tready = r_grant;
        end
    end

    // Grant bookkeeping and the rotating-priority pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant      <= '0;
            r_grant_idx  <= '0;
            r_last_grant <= IDX_W'(NUM_SRC - 1);
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= w_wd_expire;
            if ((r_state == ARB_IDLE) && w_pick_valid) begin
                r_grant     <= w_pick;
                r_grant_idx <= w_pick_idx;
            end else if ((r_state == ARB_GRANT) && (w_pkt_end || w_wd_expire)) begin
                r_grant      <= '0;
                r_last_grant <= r_grant_idx;
            end
        end
    end

    // Single-entry output register; a held beat drains even after a revoke.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else if (w_load) begin
            r_m_tvalid <= w_accept;
            r_m_tlast  <= w_accept && w_sel_last;
            if (w_accept) begin
                r_m_tdata <= w_sel_data;
            end
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign o_grant       = r_grant;
    assign o_timeout     = r_timeout;

endmodule
`default_nettype wire
